// File: rtl/pr_read_arbiter.sv
// Two-requester AXI read-address arbiter with round-robin grant, per-port
// outstanding-burst limiting and rid-based response demultiplexing.
module pr_read_arbiter #(
  parameter int unsigned MAX_OUT    = 8,
  parameter logic [2:0]  ARSIZE_VAL = 3'b110
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [63:0]  req0_addr,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [63:0]  req1_addr,
  output logic         req1_ready,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m,
  output logic         resp0_valid,
  output logic [511:0] resp0_data,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  output logic [511:0] resp1_data,
  input  logic         resp1_ready,
  output logic [3:0]   outstanding0,
  output logic [3:0]   outstanding1,
  output logic         err_unknown_id,
  output logic         idle
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

  state_t       state_q, state_d;
  logic         rr_q, rr_d;
  logic [3:0]   out0_q, out0_d, out1_q, out1_d;
  logic [15:0]  arid_q, arid_d;
  logic [63:0]  araddr_q, araddr_d;
  logic         err_q, err_d;
  logic         elig0, elig1, gnt0, gnt1;
  logic         rid_is0, rid_is1, dec0, dec1;

  assign rid_is0 = (rid_m == 16'd0);
  assign rid_is1 = (rid_m == 16'd1);
  assign elig0   = req0_valid && (out0_q < MAX_OUT_W);
  assign elig1   = req1_valid && (out1_q < MAX_OUT_W);

  // Grants are suppressed under reset so no requester sees a phantom accept.
  assign gnt0 = (state_q == IDLE) && !rst && elig0 && (!elig1 || !rr_q);
  assign gnt1 = (state_q == IDLE) && !rst && elig1 && (!elig0 ||  rr_q);

  // Unknown ids are always accepted so a stray response cannot stall the bus.
  always_comb begin
    rready_m = 1'b1;
    if (rid_is0)      rready_m = resp0_ready;
    else if (rid_is1) rready_m = resp1_ready;
  end

  assign dec0 = rvalid_m && rready_m && rlast_m && rid_is0;
  assign dec1 = rvalid_m && rready_m && rlast_m && rid_is1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      out0_q   <= 4'd0;
      out1_q   <= 4'd0;
      arid_q   <= 16'd0;
      araddr_q <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt0 || gnt1) state_d = ISSUE;
      ISSUE:   if (arready_m)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d     = rr_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    err_d    = err_q || (rvalid_m && !rid_is0 && !rid_is1);
    if (gnt0) begin
      rr_d     = 1'b1;
      arid_d   = 16'd0;
      araddr_d = req0_addr;
    end else if (gnt1) begin
      rr_d     = 1'b0;
      arid_d   = 16'd1;
      araddr_d = req1_addr;
    end
    out0_d = out0_q;
    case ({gnt0, dec0})
      2'b10:   out0_d = out0_q + 4'd1;
      2'b01:   out0_d = (out0_q == 4'd0) ? 4'd0 : out0_q - 4'd1;
      default: out0_d = out0_q;
    endcase
    out1_d = out1_q;
    case ({gnt1, dec1})
      2'b10:   out1_d = out1_q + 4'd1;
      2'b01:   out1_d = (out1_q == 4'd0) ? 4'd0 : out1_q - 4'd1;
      default: out1_d = out1_q;
    endcase
  end

  always_comb begin
    req0_ready     = gnt0;
    req1_ready     = gnt1;
    arvalid_m      = (state_q == ISSUE);
    arid_m         = arid_q;
    araddr_m       = araddr_q;
    arlen_m        = 8'd0;
    arsize_m       = ARSIZE_VAL;
    resp0_valid    = rvalid_m && rid_is0;
    resp1_valid    = rvalid_m && rid_is1;
    resp0_data     = rdata_m;
    resp1_data     = rdata_m;
    outstanding0   = out0_q;
    outstanding1   = out1_q;
    err_unknown_id = err_q;
    idle           = (state_q == IDLE) && (out0_q == 4'd0) && (out1_q == 4'd0);
  end

endmodule

// File: tb/tb_pr_read_arbiter.sv
// Directed bench for pr_read_arbiter: default instance plus a MAX_OUT=2
// instance sharing the same stimulus.
module tb_pr_read_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, arready_m, rlast_m, rvalid_m;
  logic         resp0_ready, resp1_ready;
  logic [63:0]  req0_addr, req1_addr;
  logic [15:0]  rid_m;
  logic [511:0] rdata_m;

  logic         req0_ready, req1_ready, arvalid_m, rready_m;
  logic         resp0_valid, resp1_valid, err_unknown_id, idle;
  logic [15:0]  arid_m;
  logic [63:0]  araddr_m;
  logic [7:0]   arlen_m;
  logic [2:0]   arsize_m;
  logic [511:0] resp0_data, resp1_data;
  logic [3:0]   outstanding0, outstanding1;

  logic         b_req0_ready, b_req1_ready, b_arvalid_m, b_rready_m;
  logic         b_resp0_valid, b_resp1_valid, b_err_unknown_id, b_idle;
  logic [15:0]  b_arid_m;
  logic [63:0]  b_araddr_m;
  logic [7:0]   b_arlen_m;
  logic [2:0]   b_arsize_m;
  logic [511:0] b_resp0_data, b_resp1_data;
  logic [3:0]   b_outstanding0, b_outstanding1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pr_read_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m),
    .rready_m(rready_m),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(resp1_ready),
    .outstanding0(outstanding0), .outstanding1(outstanding1),
    .err_unknown_id(err_unknown_id), .idle(idle)
  );

  pr_read_arbiter #(.MAX_OUT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(b_req1_ready),
    .arid_m(b_arid_m), .araddr_m(b_araddr_m), .arlen_m(b_arlen_m), .arsize_m(b_arsize_m),
    .arvalid_m(b_arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m),
    .rready_m(b_rready_m),
    .resp0_valid(b_resp0_valid), .resp0_data(b_resp0_data), .resp0_ready(resp0_ready),
    .resp1_valid(b_resp1_valid), .resp1_data(b_resp1_data), .resp1_ready(resp1_ready),
    .outstanding0(b_outstanding0), .outstanding1(b_outstanding1),
    .err_unknown_id(b_err_unknown_id), .idle(b_idle)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; req0_addr = '0; req1_addr = '0;
    arready_m = 0; rid_m = '0; rdata_m = '0; rlast_m = 0; rvalid_m = 0;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({arvalid_m, arid_m, araddr_m, outstanding0, outstanding1, err_unknown_id, idle}
        !== {1'b0, 16'd0, 64'd0, 4'd0, 4'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: arvalid=%0b arid=%0h araddr=%0h o0=%0d o1=%0d err=%0b idle=%0b",
               arvalid_m, arid_m, araddr_m, outstanding0, outstanding1, err_unknown_id, idle);
    else passed++;
    total++;
    if ({arlen_m, arsize_m} !== {8'd0, 3'b110})
      $display("FAIL ar_constants: arlen=%0d arsize=%0b expected 0/110", arlen_m, arsize_m);
    else passed++;
    rst = 1; req0_valid = 1; req1_valid = 1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("FAIL reset_blocks_grant: ready=%b expected 00", {req0_ready, req1_ready});
    else passed++;
    step();
    total++;
    if (arvalid_m !== 1'b0)
      $display("FAIL reset_no_issue: arvalid=%0b expected 0", arvalid_m);
    else passed++;
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_addr;
    do_reset();
    req0_addr = 64'h0000_1000_0000_0040; req1_addr = 64'h0000_2000_0000_0080;
    req0_valid = 1; req1_valid = 1; arready_m = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? req0_addr : req1_addr;
      total++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_grant%0d: ready=%b expected %b", i, {req0_ready, req1_ready},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      else passed++;
      step();
      total++;
      if ({arvalid_m, arid_m, araddr_m, req0_ready, req1_ready}
          !== {1'b1, 16'(i % 2), exp_addr, 2'b00})
        $display("FAIL rr_issue%0d: arvalid=%0b arid=%0h araddr=%0h ready=%b expected 1/%0h/%0h/00",
                 i, arvalid_m, arid_m, araddr_m, {req0_ready, req1_ready}, i % 2, exp_addr);
      else passed++;
      $display("rr transaction %0d: arid=%0h araddr=%0h", i, arid_m, araddr_m);
      if (i == 3) begin req0_valid = 0; req1_valid = 0; end
      step();
    end
    total++;
    if ({outstanding0, outstanding1, arvalid_m} !== {4'd2, 4'd2, 1'b0})
      $display("FAIL rr_counts: o0=%0d o1=%0d arvalid=%0b expected 2/2/0",
               outstanding0, outstanding1, arvalid_m);
    else passed++;
  endtask

  task automatic test_max_out();
    int grants;
    do_reset();
    req1_addr = 64'h0000_0000_dead_0000; req1_valid = 1; arready_m = 1;
    #1;
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      if (b_req1_ready === 1'b1) grants++;
      step();
    end
    total++;
    if (grants !== 2)
      $display("FAIL maxout_grants: grants=%0d expected 2", grants);
    else passed++;
    total++;
    if ({b_outstanding1, b_req1_ready} !== {4'd2, 1'b0})
      $display("FAIL maxout_count: o1=%0d ready=%0b expected 2/0", b_outstanding1, b_req1_ready);
    else passed++;
    rvalid_m = 1; rid_m = 16'd1; rlast_m = 1; resp1_ready = 1;
    #1;
    total++;
    if ({b_rready_m, b_resp1_valid, b_resp0_valid} !== 3'b110)
      $display("FAIL maxout_resp_route: rready/v1/v0=%b expected 110",
               {b_rready_m, b_resp1_valid, b_resp0_valid});
    else passed++;
    step();
    rvalid_m = 0; rlast_m = 0;
    #1;
    total++;
    if ({b_outstanding1, b_req1_ready} !== {4'd1, 1'b1})
      $display("FAIL maxout_third_grant: o1=%0d ready=%0b expected 1/1", b_outstanding1, b_req1_ready);
    else passed++;
    $display("maxout transaction: third grant o1=%0d", b_outstanding1);
    req1_valid = 0;
    step();
  endtask

  task automatic test_stall();
    do_reset();
    req0_addr = 64'h0123_4567_89ab_cdc0; req1_addr = 64'h0fed_cba9_8765_4300;
    req0_valid = 1; req1_valid = 1; arready_m = 0;
    #1;
    total++;
    if (req0_ready !== 1'b1)
      $display("FAIL stall_first_grant: req0_ready=%0b expected 1", req0_ready);
    else passed++;
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({arvalid_m, arid_m, araddr_m, req0_ready, req1_ready}
          !== {1'b1, 16'd0, 64'h0123_4567_89ab_cdc0, 2'b00})
        $display("FAIL stall_hold%0d: arvalid=%0b arid=%0h araddr=%0h ready=%b expected 1/0/123456789abcdc0/00",
                 i, arvalid_m, arid_m, araddr_m, {req0_ready, req1_ready});
      else passed++;
      step();
    end
    arready_m = 1;
    step();
    total++;
    if ({arvalid_m, req1_ready, req0_ready} !== 3'b010)
      $display("FAIL stall_release: arvalid/r1/r0=%b expected 010", {arvalid_m, req1_ready, req0_ready});
    else passed++;
    $display("stall transaction: released, port1 granted");
    req0_valid = 0; req1_valid = 0;
    step();
  endtask

  task automatic test_same_cycle();
    do_reset();
    req0_addr = 64'h40; req0_valid = 1; arready_m = 1;
    repeat (6) step();
    rvalid_m = 1; rid_m = 16'd0; rlast_m = 1; resp0_ready = 1;
    rdata_m = {16{32'hA5A5_0000}};
    #1;
    total++;
    if ({outstanding0, req0_ready, resp0_valid, rready_m, resp0_data}
        !== {4'd3, 1'b1, 1'b1, 1'b1, {16{32'hA5A5_0000}}})
      $display("FAIL same_pre: o0=%0d ready=%0b v0=%0b rready=%0b data_ok=%0b expected 3/1/1/1/1",
               outstanding0, req0_ready, resp0_valid, rready_m, resp0_data === {16{32'hA5A5_0000}});
    else passed++;
    step();
    rvalid_m = 0; rlast_m = 0; req0_valid = 0;
    total++;
    if (outstanding0 !== 4'd3)
      $display("FAIL same_cycle_hold: o0=%0d expected 3", outstanding0);
    else passed++;
    step();
    rvalid_m = 1; rlast_m = 0; resp0_ready = 1;
    step();
    total++;
    if (outstanding0 !== 4'd3)
      $display("FAIL nonlast_beat: o0=%0d expected 3", outstanding0);
    else passed++;
    rlast_m = 1; resp0_ready = 0;
    #1;
    total++;
    if (rready_m !== 1'b0)
      $display("FAIL backpressure: rready=%0b expected 0", rready_m);
    else passed++;
    step();
    resp0_ready = 1;
    step();
    rvalid_m = 0; rlast_m = 0;
    total++;
    if (outstanding0 !== 4'd2)
      $display("FAIL plain_decrement: o0=%0d expected 2", outstanding0);
    else passed++;
    $display("same-cycle transaction: o0=%0d", outstanding0);
  endtask

  task automatic test_unknown_id();
    do_reset();
    rvalid_m = 1; rid_m = 16'd5; rdata_m = {16{32'h1234_5678}};
    resp0_ready = 0; resp1_ready = 0;
    #1;
    total++;
    if ({rready_m, resp0_valid, resp1_valid, err_unknown_id} !== 4'b1000)
      $display("FAIL unknown_route: rready/v0/v1/err=%b expected 1000",
               {rready_m, resp0_valid, resp1_valid, err_unknown_id});
    else passed++;
    step();
    rid_m = 16'd1; rlast_m = 0;
    #1;
    total++;
    if ({err_unknown_id, resp1_valid, resp0_valid, rready_m} !== 4'b1100)
      $display("FAIL unknown_sticky_route1: err/v1/v0/rready=%b expected 1100",
               {err_unknown_id, resp1_valid, resp0_valid, rready_m});
    else passed++;
    total++;
    if (resp1_data !== {16{32'h1234_5678}})
      $display("FAIL resp1_data: got %0h expected %0h", resp1_data[31:0], 32'h1234_5678);
    else passed++;
    rvalid_m = 0;
    repeat (3) step();
    total++;
    if (err_unknown_id !== 1'b1)
      $display("FAIL unknown_sticky: err=%0b expected 1", err_unknown_id);
    else passed++;
    rst = 1;
    step();
    rst = 0;
    total++;
    if (err_unknown_id !== 1'b0)
      $display("FAIL unknown_cleared: err=%0b expected 0", err_unknown_id);
    else passed++;
    $display("unknown-id transaction: flag cleared by reset");
  endtask

  task automatic test_reset_issue();
    do_reset();
    req0_addr = 64'h80; req0_valid = 1; arready_m = 1;
    repeat (3) step();
    req0_valid = 0; arready_m = 0;
    #1;
    total++;
    if ({arvalid_m, outstanding0} !== {1'b1, 4'd2})
      $display("FAIL rstissue_pre: arvalid=%0b o0=%0d expected 1/2", arvalid_m, outstanding0);
    else passed++;
    rst = 1;
    step();
    rst = 0;
    total++;
    if ({arvalid_m, outstanding0, idle} !== {1'b0, 4'd0, 1'b1})
      $display("FAIL rstissue_post: arvalid=%0b o0=%0d idle=%0b expected 0/0/1",
               arvalid_m, outstanding0, idle);
    else passed++;
    rvalid_m = 1; rid_m = 16'd0; rlast_m = 1; resp0_ready = 1;
    step();
    rvalid_m = 0; rlast_m = 0;
    total++;
    if ({outstanding0, idle} !== {4'd0, 1'b1})
      $display("FAIL rstissue_saturate: o0=%0d idle=%0b expected 0/1", outstanding0, idle);
    else passed++;
    $display("reset-in-issue transaction: o0=%0d", outstanding0);
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_max_out();
    test_stall();
    test_same_cycle();
    test_unknown_id();
    test_reset_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
